mmio_uart: RTL and testbench

- Memory-mapped peripheral that replaces the bit-banged UART TX/RX and LED flops in the SoC wrapper.
- Provides a hardware 8N1 UART with parametrised TX and RX FIFOs, a runtime-writable baud divisor, status/error flags, an LED register and an RX interrupt level.
- Sits behind the pipeline's mapped-I/O decode (mem_addr[28]=1); the wrapper passes mem_addr[15:12] as the register index and muxes rdata into the pipeline's read data.

---
 rtl/mmio_uart.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_mmio_uart.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart.sv
// mmio_uart: memory-mapped 8N1 UART with TX/RX FIFOs, baud divisor,
// status flags, LED register and RX-level interrupt.

module mmio_uart_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PONE = (AW+1)'(1);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wp_q;
  logic [AW:0]  rp_q;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wp_q == rp_q);
  // Same index, opposite wrap bit: the writer is a full lap ahead.
  assign full_o  = (wp_q[AW-1:0] == rp_q[AW-1:0]) &&
                   (wp_q[AW] != rp_q[AW]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q <= '0;
      rp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wp_q[AW-1:0]] <= data_i;
        wp_q <= wp_q + PONE;
      end
      if (do_pop) rp_q <= rp_q + PONE;
    end
  end

endmodule

module mmio_uart #(
  parameter int CLOCK_RATE = 12_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4,
  parameter int LED_WIDTH  = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 sel,
  input  logic                 wren,
  input  logic [3:0]           addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 irq
);

  localparam int DIV_RST = CLOCK_RATE / BAUD_RATE;
  localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(4);
  localparam logic [DIV_WIDTH-1:0] ONE_D   = DIV_WIDTH'(1);

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_st_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
  } rx_st_e;

  logic [31:0]          rdata_q;
  logic [31:0]          rdata_d;
  logic [LED_WIDTH-1:0] leds_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_m1;
  logic [DIV_WIDTH-1:0] wdiv;
  logic                 ovr_q;
  logic                 ferr_q;

  logic rd_en;
  logic wr_en;
  logic flag_clr;
  logic unused_wdata;

  logic       txf_push;
  logic       txf_pop;
  logic [7:0] txf_data;
  logic       txf_full;
  logic       txf_empty;

  logic       rxf_push;
  logic       rxf_pop;
  logic [7:0] rxf_data;
  logic       rxf_full;
  logic       rxf_empty;

  tx_st_e               tx_st_q;
  logic                 tx_q;
  logic [DIV_WIDTH-1:0] tx_cnt_q;
  logic [2:0]           tx_bit_q;
  logic [7:0]           tx_sh_q;
  logic                 tx_idle;

  logic                 rx_m_q;
  logic                 rx_s_q;
  logic                 rx_p_q;
  rx_st_e               rx_st_q;
  logic [DIV_WIDTH-1:0] rx_cnt_q;
  logic [2:0]           rx_bit_q;
  logic [7:0]           rx_sh_q;
  logic                 rx_stop_tick;
  logic                 ovr_set;
  logic                 ferr_set;

  logic [31:0] leds_ext;
  logic [31:0] div_ext;
  logic [31:0] status;

  assign rd_en    = sel & ~wren;
  assign wr_en    = sel & wren;
  assign flag_clr = wr_en && (addr == 4'd2);
  assign wdiv     = wdata[DIV_WIDTH-1:0];
  assign div_m1   = div_q - ONE_D;
  assign unused_wdata = ^wdata;

  assign txf_push = wr_en && (addr == 4'd0);
  assign rxf_pop  = rd_en && (addr == 4'd0);

  mmio_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_txf (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (txf_push),
    .data_i  (wdata[7:0]),
    .pop_i   (txf_pop),
    .data_o  (txf_data),
    .full_o  (txf_full),
    .empty_o (txf_empty)
  );

  mmio_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rxf (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (rxf_push),
    .data_i  (rx_sh_q),
    .pop_i   (rxf_pop),
    .data_o  (rxf_data),
    .full_o  (rxf_full),
    .empty_o (rxf_empty)
  );

  // A new frame is loaded from idle or at the end of a stop bit.
  assign txf_pop = ~txf_empty &&
                   ((tx_st_q == TX_IDLE) ||
                    ((tx_st_q == TX_STOP) && (tx_cnt_q == '0)));
  assign tx_idle = txf_empty && (tx_st_q == TX_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_st_q  <= TX_IDLE;
      tx_q     <= 1'b1;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
    end else if (txf_pop) begin
      tx_st_q  <= TX_START;
      tx_q     <= 1'b0;
      tx_sh_q  <= txf_data;
      tx_cnt_q <= div_m1;
    end else begin
      case (tx_st_q)
        TX_IDLE: tx_q <= 1'b1;
        TX_START: begin
          if (tx_cnt_q == '0) begin
            tx_st_q  <= TX_DATA;
            tx_q     <= tx_sh_q[0];
            tx_bit_q <= '0;
            tx_cnt_q <= div_m1;
          end else begin
            tx_cnt_q <= tx_cnt_q - ONE_D;
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == '0) begin
            tx_cnt_q <= div_m1;
            if (tx_bit_q == 3'd7) begin
              tx_st_q <= TX_STOP;
              tx_q    <= 1'b1;
            end else begin
              tx_q     <= tx_sh_q[1];
              tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
              tx_bit_q <= tx_bit_q + 3'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - ONE_D;
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == '0) tx_st_q <= TX_IDLE;
          else tx_cnt_q <= tx_cnt_q - ONE_D;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_p_q <= 1'b1;
    end else begin
      rx_m_q <= uart_rx;
      rx_s_q <= rx_m_q;
      rx_p_q <= rx_s_q;
    end
  end

  assign rx_stop_tick = (rx_st_q == RX_STOP) && (rx_cnt_q == '0);
  assign rxf_push     = rx_stop_tick & rx_s_q;
  assign ferr_set     = rx_stop_tick & ~rx_s_q;
  // Pop only succeeds when non-empty, so a full FIFO frees a slot iff popped.
  assign ovr_set      = rxf_push & rxf_full & ~rxf_pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_st_q  <= RX_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
    end else begin
      case (rx_st_q)
        RX_IDLE: begin
          if (!rx_s_q && rx_p_q) begin
            rx_st_q  <= RX_START;
            rx_cnt_q <= (div_q >> 1) - ONE_D;
          end
        end
        RX_START: begin
          if (rx_cnt_q == '0) begin
            if (rx_s_q) begin
              rx_st_q <= RX_IDLE;
            end else begin
              rx_st_q  <= RX_DATA;
              rx_bit_q <= '0;
              rx_cnt_q <= div_m1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - ONE_D;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == '0) begin
            rx_sh_q  <= {rx_s_q, rx_sh_q[7:1]};
            rx_cnt_q <= div_m1;
            if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
            else rx_bit_q <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q - ONE_D;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == '0) begin
            rx_st_q <= rx_s_q ? RX_IDLE : RX_WAIT;
          end else begin
            rx_cnt_q <= rx_cnt_q - ONE_D;
          end
        end
        RX_WAIT: if (rx_s_q) rx_st_q <= RX_IDLE;
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  assign leds_ext = 32'(leds_q);
  assign div_ext  = 32'(div_q);
  assign status   = {27'b0, ferr_q, ovr_q, ~rxf_empty, tx_idle, txf_full};

  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      unique case (addr)
        4'd0: if (!rxf_empty) rdata_d = {23'b0, 1'b1, rxf_data};
        4'd1: rdata_d = leds_ext;
        4'd2: rdata_d = status;
        4'd4: rdata_d = div_ext;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q <= '0;
      leds_q  <= '0;
      div_q   <= DIV_WIDTH'(DIV_RST);
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      if (wr_en && (addr == 4'd1)) leds_q <= wdata[LED_WIDTH-1:0];
      if (wr_en && (addr == 4'd4)) div_q <= (wdiv < DIV_MIN) ? DIV_MIN : wdiv;
      ovr_q  <= ovr_set  | (ovr_q  & ~flag_clr);
      ferr_q <= ferr_set | (ferr_q & ~flag_clr);
    end
  end

  assign rdata   = rdata_q;
  assign uart_tx = tx_q;
  assign leds    = leds_q;
  assign irq     = ~rxf_empty;

endmodule

// File: tb/tb_mmio_uart.sv
// Scoreboard bench for mmio_uart: reads and TX frames are queued as
// expectations and checked by independent monitors.
`timescale 1ns/1ps

module tb_mmio_uart;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sel;
  logic        wren;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        uart_rx;
  logic        uart_tx;
  logic [7:0]  leds;
  logic        irq;

  typedef struct {
    logic [31:0] data;
    string       name;
  } rd_t;

  typedef struct {
    logic [7:0] data;
    int         gap;
  } tx_t;

  rd_t rd_exp[$];
  tx_t tx_exp[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit tx_mon_en = 1'b1;

  mmio_uart #(
    .CLOCK_RATE (1024),
    .BAUD_RATE  (32),
    .FIFO_DEPTH (4),
    .LED_WIDTH  (8),
    .DIV_WIDTH  (16)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .sel     (sel),
    .wren    (wren),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .leds    (leds),
    .irq     (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc_wait(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [3:0] a, logic [31:0] d);
    sel = 1'b1; wren = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    sel = 1'b0; wren = 1'b0;
  endtask

  task automatic rd(logic [3:0] a, logic [31:0] e, string nm);
    rd_exp.push_back('{e, nm});
    sel = 1'b1; wren = 1'b0; addr = a;
    @(posedge clk);
    #1;
    sel = 1'b0;
  endtask

  task automatic send_rx(logic [7:0] b, logic stp);
    uart_rx = 1'b0;
    cyc_wait(32);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      cyc_wait(32);
    end
    uart_rx = stp;
    cyc_wait(32);
    uart_rx = 1'b1;
  endtask

  task automatic wait_tx(int lim);
    int n;
    n = 0;
    while (tx_exp.size() != 0 && n < lim) begin
      @(posedge clk);
      n++;
    end
    n_chk++;
    if (tx_exp.size() != 0) begin
      n_fail++;
      $display("FAIL tx_drain: %0d frames pending, expected 0", tx_exp.size());
      tx_exp.delete();
    end
    cyc_wait(40);
  endtask

  // Read monitor: a read sampled on a rising edge shows up on rdata after it.
  initial begin : rd_mon
    rd_t e;
    forever begin
      @(posedge clk);
      if (sel === 1'b1 && wren === 1'b0) begin
        @(negedge clk);
        if (rd_exp.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rd_unexpected: got 0x%0h, expected no read", rdata);
        end else begin
          e = rd_exp.pop_front();
          check(e.name, rdata, e.data);
        end
      end
    end
  end

  // TX monitor: decodes frames at mid-bit, divisor 32.
  initial begin : tx_mon
    tx_t        e;
    int         st;
    int         last_st;
    logic [7:0] b;
    logic       stp;
    last_st = -100000;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        st = cyc;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (32) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (32) @(negedge clk);
        stp = uart_tx;
        if (tx_mon_en) begin
          if (tx_exp.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL tx_unexpected: got frame 0x%0h, expected none", b);
          end else begin
            e = tx_exp.pop_front();
            check("tx_byte", 32'(b), 32'(e.data));
            check("tx_stop", 32'(stp), 32'd1);
            if (e.gap >= 0) check("tx_gap", st - last_st, e.gap);
          end
        end
        last_st = st;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] burst [5];
    int         bad;
    logic       eb;
    logic [7:0] b55;
    burst[0] = 8'h01; burst[1] = 8'h80; burst[2] = 8'hFF;
    burst[3] = 8'h3C; burst[4] = 8'hA5;
    b55 = 8'h55;

    rstn = 1'b0; sel = 1'b0; wren = 1'b0; addr = '0; wdata = '0;
    uart_rx = 1'b1;
    cyc_wait(5);
    rstn = 1'b1;
    cyc_wait(2);

    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rd(4'd2, 32'h02, "rst_status");
    rd(4'd4, 32'd32, "rst_div");

    // Single frame, exact waveform and tx_idle boundary.
    tx_exp.push_back('{8'h55, -1});
    wr(4'd0, 32'h55);
    @(negedge clk);
    check("tx_pre_start", 32'(uart_tx), 32'd1);
    for (int k = 0; k < 10; k++) begin
      eb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b55[k-1];
      bad = 0;
      for (int j = 0; j < 32; j++) begin
        @(negedge clk);
        if (uart_tx !== eb) bad++;
      end
      check("tx55_bit_bad_cycles", bad, 0);
    end
    rd(4'd2, 32'h00, "tx_stop_busy");
    rd(4'd2, 32'h02, "tx_idle_320");
    cyc_wait(20);

    // Five writes while idle: all fit, frames contiguous.
    for (int i = 0; i < 5; i++) begin
      tx_exp.push_back('{burst[i], (i == 0) ? -1 : 320});
      wr(4'd0, 32'(burst[i]));
    end
    wait_tx(3000);

    // Six writes: first starts, four queue, sixth dropped.
    for (int i = 0; i < 6; i++) begin
      if (i < 5) tx_exp.push_back('{8'(8'h10 + i), (i == 0) ? -1 : 320});
      wr(4'd0, 32'h10 + i);
    end
    rd(4'd2, 32'h01, "tx_full");
    wait_tx(3000);
    rd(4'd2, 32'h02, "tx_drop_idle");

    // RX single byte.
    send_rx(8'hA3, 1'b1);
    cyc_wait(2);
    check("rx_irq_set", 32'(irq), 32'd1);
    rd(4'd0, 32'h1A3, "rx_a3");
    rd(4'd0, 32'h0, "rx_empty_read");
    cyc_wait(1);
    check("rx_irq_clr", 32'(irq), 32'd0);

    // RX overrun: five frames into a depth-4 FIFO.
    for (int i = 1; i <= 5; i++) send_rx(8'(8'h11 * i), 1'b1);
    cyc_wait(2);
    rd(4'd2, 32'h0E, "ovr_status");
    for (int i = 1; i <= 4; i++) rd(4'd0, 32'h100 | (32'h11 * i), "ovr_data");
    rd(4'd0, 32'h0, "ovr_drained");
    wr(4'd2, 32'h0);
    rd(4'd2, 32'h02, "ovr_cleared");

    // Framing error.
    send_rx(8'h5A, 1'b0);
    cyc_wait(4);
    rd(4'd2, 32'h12, "ferr_status");
    check("ferr_no_irq", 32'(irq), 32'd0);
    wr(4'd2, 32'h0);
    rd(4'd2, 32'h02, "ferr_cleared");

    // Short low glitch.
    uart_rx = 1'b0;
    cyc_wait(10);
    uart_rx = 1'b1;
    cyc_wait(400);
    rd(4'd2, 32'h02, "glitch_status");
    check("glitch_irq", 32'(irq), 32'd0);

    // LEDs and reserved indices.
    wr(4'd1, 32'hFFFF_FF3C);
    check("leds_out", 32'(leds), 32'h3C);
    rd(4'd1, 32'h3C, "leds_read");
    wr(4'd3, 32'hDEAD_BEEF);
    rd(4'd3, 32'h0, "reserved3");
    wr(4'd9, 32'h1234);
    rd(4'd9, 32'h0, "reserved9");

    // Divisor writes with floor of 4.
    wr(4'd4, 32'd100);
    rd(4'd4, 32'd100, "div_100");
    wr(4'd4, 32'd2);
    rd(4'd4, 32'd4, "div_min");

    // Reset in mid-frame returns the line high at once.
    tx_mon_en = 1'b0;
    wr(4'd0, 32'h00);
    cyc_wait(3);
    check("tx_low_midframe", 32'(uart_tx), 32'd0);
    rstn = 1'b0;
    #1;
    check("rst_midframe_tx", 32'(uart_tx), 32'd1);
    cyc_wait(2);
    rstn = 1'b1;
    cyc_wait(2);
    rd(4'd4, 32'd32, "rst_div_restore");
    rd(4'd2, 32'h02, "rst_status_restore");

    cyc_wait(3);
    check("rd_queue_empty", rd_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
